t03_text_render_ctrl: RTL

Sequencer that drives the single-character glyph lookup and streams a 12-character text line to the display writer one 9-pixel glyph row at a time. It latches a string of 6-bit character codes on `start` and walks it in display (raster) order: line 0 of every character, then line 1, through line 7. For each row it presents the code to the glyph LUT and registers the returned row slice. It then offers that slice on a valid/ready stream to the framebuffer/SPI writer. It replaces instantiating one LUT per character with one shared LUT plus this scheduler.

---
 rtl/t03_text_render_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/t03_text_render_ctrl.sv
// Shares one glyph LUT across a 12-character text line and streams the glyph
// rows to the display writer in raster order over a valid/ready handshake.
module t03_text_render_ctrl #(
    parameter int NUM_CHARS = 12,
    parameter int CHAR_BITS = 6,
    parameter int GLYPH_W   = 9,
    parameter int GLYPH_H   = 8,
    localparam int STR_W    = NUM_CHARS * CHAR_BITS,
    localparam int GWORD_W  = GLYPH_W * GLYPH_H,
    localparam int CI_W     = $clog2(NUM_CHARS),
    localparam int LI_W     = $clog2(GLYPH_H)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [STR_W-1:0]     text_in,
    output logic [CHAR_BITS-1:0] glyph_code,
    input  logic [GWORD_W-1:0]   glyph_bits,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [GLYPH_W-1:0]   row_bits,
    output logic [CI_W-1:0]      row_char,
    output logic [LI_W-1:0]      row_line,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CI_W-1:0] LAST_CHAR = CI_W'(NUM_CHARS - 1);
    localparam logic [LI_W-1:0] LAST_LINE = LI_W'(GLYPH_H - 1);

    logic [1:0]           state_q,    state_d;
    logic [STR_W-1:0]     str_q,      str_d;
    logic [CI_W-1:0]      char_idx_q, char_idx_d;
    logic [LI_W-1:0]      line_idx_q, line_idx_d;
    logic [GLYPH_W-1:0]   row_bits_q, row_bits_d;
    logic [CI_W-1:0]      row_char_q, row_char_d;
    logic [LI_W-1:0]      row_line_q, row_line_d;
    logic [GLYPH_W-1:0]   glyph_row;

    // Character 0 sits in the MSBs of the string, glyph row 0 in the MSBs of the LUT word.
    always_comb begin
        glyph_code = '0;
        for (int c = 0; c < NUM_CHARS; c++) begin
            if (char_idx_q == CI_W'(c)) begin
                glyph_code = str_q[STR_W-1-CHAR_BITS*c -: CHAR_BITS];
            end
        end
    end

    always_comb begin
        glyph_row = '0;
        for (int l = 0; l < GLYPH_H; l++) begin
            if (line_idx_q == LI_W'(l)) begin
                glyph_row = glyph_bits[GWORD_W-1-GLYPH_W*l -: GLYPH_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        str_d      = str_q;
        char_idx_d = char_idx_q;
        line_idx_d = line_idx_q;
        row_bits_d = row_bits_q;
        row_char_d = row_char_q;
        row_line_d = row_line_q;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    str_d      = text_in;
                    char_idx_d = '0;
                    line_idx_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                row_bits_d = glyph_row;
                row_char_d = char_idx_q;
                row_line_d = line_idx_q;
                state_d    = S_SEND;
            end
            S_SEND: begin
                if (row_ready) begin
                    state_d = S_FETCH;
                    if (char_idx_q == LAST_CHAR) begin
                        char_idx_d = '0;
                        line_idx_d = line_idx_q + 1'b1;
                        if (line_idx_q == LAST_LINE) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        char_idx_d = char_idx_q + 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Cancel wins over a handshake landing in the same cycle.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            str_q      <= '0;
            char_idx_q <= '0;
            line_idx_q <= '0;
            row_bits_q <= '0;
            row_char_q <= '0;
            row_line_q <= '0;
        end else begin
            state_q    <= state_d;
            str_q      <= str_d;
            char_idx_q <= char_idx_d;
            line_idx_q <= line_idx_d;
            row_bits_q <= row_bits_d;
            row_char_q <= row_char_d;
            row_line_q <= row_line_d;
        end
    end

    assign row_valid = (state_q == S_SEND);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign row_bits  = row_bits_q;
    assign row_char  = row_char_q;
    assign row_line  = row_line_q;

endmodule
